// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 SPI link arbiter.
package ili9341_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int SPI_BYTE_W = 8;

  // Requester indices: the initialiser is port 0, the pixel raster port 1.
  localparam logic REQ_INIT   = 1'b0;
  localparam logic REQ_RASTER = 1'b1;

  // Choose a requester among the valid ones. A lone requester always wins;
  // on a tie, fixed priority favours REQ_INIT and round-robin favours
  // whichever port did not own the previous transaction.
  function automatic logic pick_grant(input logic v0, input logic v1,
                                      input logic rr, input logic last_owner);
    logic g;
    if (v0 && v1) begin
      g = rr ? ~last_owner : REQ_INIT;
    end else if (v1) begin
      g = REQ_RASTER;
    end else begin
      g = REQ_INIT;
    end
    return g;
  endfunction

endpackage

// File: rtl/ili9341_spi_arbiter_if.sv
// Per-requester byte-stream handshake. The requester drives the master side,
// the arbiter the slave side; ack is a one-cycle capture pulse.
interface ili9341_spi_arbiter_if;
  import ili9341_pkg::*;

  logic                  valid;
  logic [SPI_BYTE_W-1:0] data;
  logic                  dc;
  logic                  last;
  logic                  ack;

  modport master (output valid, output data, output dc, output last, input ack);
  modport slave  (input valid, input data, input dc, input last, output ack);

endinterface

// File: rtl/ili9341_spi_byte_shifter.sv
// SPI mode 0 byte serialiser: sclk idles low, din moves after each falling
// edge, MSB first. One byte is 16 half-periods of CLK_DIV clk cycles each.
module ili9341_spi_byte_shifter
  import ili9341_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [SPI_BYTE_W-1:0] data,
  output logic                  done,
  output logic                  sclk,
  output logic                  din
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic             active_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [3:0]       phase_r;
  // Bits still to be sent; bit 7 goes straight to din on load.
  logic [6:0]       shift_r;
  logic             expire_s;

  // Half-period expiry and end-of-byte strobe (expiry of half-period 15).
  always_comb begin
    expire_s = 1'b0;
    done     = 1'b0;
    if (active_r && (div_cnt_r == DIV_W'(CLK_DIV - 1))) begin
      expire_s = 1'b1;
      done     = (phase_r == 4'd15);
    end else begin
      expire_s = 1'b0;
      done     = 1'b0;
    end
  end

  // Divider, half-period counter, sclk toggle and MSB-first data shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r  <= 1'b0;
      div_cnt_r <= '0;
      phase_r   <= 4'd0;
      shift_r   <= 7'd0;
      sclk      <= 1'b0;
      din       <= 1'b0;
    end else if (load) begin
      active_r  <= 1'b1;
      div_cnt_r <= '0;
      phase_r   <= 4'd0;
      shift_r   <= data[6:0];
      sclk      <= 1'b0;
      din       <= data[7];
    end else if (expire_s) begin
      div_cnt_r <= '0;
      phase_r   <= phase_r + 4'd1;
      sclk      <= ~sclk;
      if (sclk) begin
        // Falling edge: present the next lower bit.
        din     <= shift_r[6];
        shift_r <= {shift_r[5:0], 1'b0};
      end
      if (phase_r == 4'd15) begin
        active_r <= 1'b0;
      end
    end else if (active_r) begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ili9341_spi_arbiter.sv
// Shares one ILI9341 SPI link between the initialiser (req0) and the pixel
// raster (req1). Bytes are taken one at a time with a req/ack handshake; a
// transaction stays locked to its owner until a byte marked last is sent.
module ili9341_spi_arbiter
  import ili9341_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int CS_GAP   = 2,
  parameter int ARB_MODE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  ili9341_spi_arbiter_if.slave        req0,
  ili9341_spi_arbiter_if.slave        req1,
  output logic                        tft_cs,
  output logic                        tft_dc,
  output logic                        tft_clk,
  output logic                        tft_din,
  output logic [1:0]                  owner,
  output logic                        busy
);

  localparam int GAP_W = $clog2(CS_GAP + 1);

  arb_state_t            state_r;
  logic                  last_owner_r;
  logic                  last_r;
  logic [GAP_W-1:0]      gap_cnt_r;
  logic                  ack0_r;
  logic                  ack1_r;

  logic                  grant_s;
  logic                  load_s;
  logic [SPI_BYTE_W-1:0] cap_data_s;
  logic                  cap_dc_s;
  logic                  cap_last_s;
  logic                  shift_done_s;

  assign req0.ack = ack0_r;
  assign req1.ack = ack1_r;

  // Decide who may hand over a byte this cycle: arbitration in IDLE, the
  // locked owner only in HOLD, nobody while shifting or in the gap.
  always_comb begin
    grant_s    = REQ_INIT;
    load_s     = 1'b0;
    cap_data_s = req0.data;
    cap_dc_s   = req0.dc;
    cap_last_s = req0.last;
    case (state_r)
      IDLE: begin
        grant_s = pick_grant(req0.valid, req1.valid, (ARB_MODE == 1), last_owner_r);
        load_s  = req0.valid | req1.valid;
      end
      HOLD: begin
        grant_s = owner[1];
        load_s  = owner[1] ? req1.valid : req0.valid;
      end
      default: begin
        grant_s = REQ_INIT;
        load_s  = 1'b0;
      end
    endcase
    if (grant_s == REQ_RASTER) begin
      cap_data_s = req1.data;
      cap_dc_s   = req1.dc;
      cap_last_s = req1.last;
    end else begin
      cap_data_s = req0.data;
      cap_dc_s   = req0.dc;
      cap_last_s = req0.last;
    end
  end

  // Transaction FSM with registered cs/dc, acks, owner and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      tft_cs       <= 1'b1;
      tft_dc       <= 1'b0;
      owner        <= 2'b00;
      busy         <= 1'b0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      last_owner_r <= REQ_RASTER;
      last_r       <= 1'b0;
      gap_cnt_r    <= '0;
    end else begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      case (state_r)
        IDLE, HOLD: begin
          if (load_s) begin
            state_r <= SHIFT;
            tft_cs  <= 1'b0;
            tft_dc  <= cap_dc_s;
            last_r  <= cap_last_s;
            busy    <= 1'b1;
            ack0_r  <= (grant_s == REQ_INIT);
            ack1_r  <= (grant_s == REQ_RASTER);
            if (state_r == IDLE) begin
              owner        <= (grant_s == REQ_RASTER) ? 2'b10 : 2'b01;
              last_owner_r <= grant_s;
            end
          end
        end
        SHIFT: begin
          if (shift_done_s) begin
            if (last_r) begin
              state_r   <= GAP;
              tft_cs    <= 1'b1;
              owner     <= 2'b00;
              gap_cnt_r <= '0;
            end else begin
              state_r <= HOLD;
            end
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_W'(CS_GAP - 1)) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  ili9341_spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (load_s),
    .data  (cap_data_s),
    .done  (shift_done_s),
    .sclk  (tft_clk),
    .din   (tft_din)
  );

endmodule
